// File: rtl/vx_vpu_state_ctrl_pkg.sv
// Shared vector-unit types and constants: per-warp vector state, raw vtype
// layout, vsetvl request modes and controller FSM states.
package VX_gpu_pkg;

    localparam int VPU_XLEN = 32;
    localparam int VPU_ELEN = 32;

    // vsetvl request modes
    localparam logic [1:0] VPU_MODE_AVL_REG = 2'd0;
    localparam logic [1:0] VPU_MODE_VLMAX   = 2'd1;
    localparam logic [1:0] VPU_MODE_KEEP_VL = 2'd2;

    // raw vtype[7:0] = {vma, vta, vsew[2:0], vlmul[2:0]}
    typedef struct packed {
        logic       vma;
        logic       vta;
        logic [2:0] vsew;
        logic [2:0] vlmul;
    } vtype_t;

    typedef struct packed {
        logic [VPU_XLEN-1:0] vl;
        logic                vill;
        logic                vma;
        logic                vta;
        logic [2:0]          vsew;
        logic [2:0]          vlmul;
    } vpu_states_t;

    typedef enum logic [1:0] {
        VPU_ST_IDLE,
        VPU_ST_CALC,
        VPU_ST_DONE
    } vpu_ctrl_state_e;

    // Table entry after reset: vl=0 with vill set, all other fields clear
    localparam vpu_states_t VPU_STATES_RESET = '{
        vl:    '0,
        vill:  1'b1,
        vma:   1'b0,
        vta:   1'b0,
        vsew:  3'd0,
        vlmul: 3'd0
    };

endpackage

// File: rtl/vx_vpu_state_ctrl_if.sv
// Vector state broadcast: one-cycle valid pulse carrying the warp id and the
// newly written vector state.
interface VX_vpu_states_if #(
    parameter int NW_WIDTH = 2
);
    import VX_gpu_pkg::*;

    logic                valid;
    logic [NW_WIDTH-1:0] wid;
    vpu_states_t         data;

    modport master (output valid, output wid, output data);
    modport slave  (input  valid, input  wid, input  data);

endinterface

// File: rtl/vx_vpu_state_ctrl_vlmax.sv
// Combinational VLMAX = VLEN*LMUL/SEW and vtype legality check, shared with
// decode-side checks.
module vx_vpu_vlmax
    import VX_gpu_pkg::*;
#(
    parameter int VLEN = 256,
    parameter int XLEN = 32
) (
    input  logic [2:0]      vsew,
    input  logic [2:0]      vlmul,
    output logic [XLEN-1:0] vlmax,
    output logic            vill
);

    int unsigned     lmul_up;
    int unsigned     lmul_down;
    logic [XLEN-1:0] sew_bits;

    // Integer LMUL scales VLEN up, fractional LMUL scales it down; SEW divides
    always_comb begin
        lmul_up   = 0;
        lmul_down = 0;
        case (vlmul)
            3'd0, 3'd1, 3'd2, 3'd3: lmul_up   = 32'(vlmul);
            3'd5, 3'd6, 3'd7:       lmul_down = 32'(4'd8 - {1'b0, vlmul});
            default:                lmul_up   = 0;
        endcase
        sew_bits = XLEN'(8) << vsew;
        vlmax    = (XLEN'(VLEN) << lmul_up) >> (32'd3 + 32'(vsew) + lmul_down);
        vill     = (sew_bits > XLEN'(VPU_ELEN)) || (vlmul == 3'd4) || (vlmax == '0);
    end

endmodule

// File: rtl/vx_vpu_state_ctrl.sv
// Per-warp vector state table (vl, vtype). vsetvl-class updates from several
// requesters are serialized by a round-robin arbiter, computed, written to the
// table, broadcast on states_if and returned as the new vl for rd writeback.
// Optional perf counters: define VX_VPU_STATE_PERF_EN.
// XLEN must equal VX_gpu_pkg::VPU_XLEN (width of vpu_states_t.vl).
module vx_vpu_state_ctrl
    import VX_gpu_pkg::*;
#(
    parameter int  NUM_WARPS = 4,
    parameter int  NUM_REQS  = 2,
    parameter int  VLEN      = 256,
    parameter int  XLEN      = 32,
    localparam int NW_WIDTH  = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,

    input  logic [NUM_REQS-1:0]          req_valid,
    output logic [NUM_REQS-1:0]          req_ready,
    input  logic [NUM_REQS*NW_WIDTH-1:0] req_wid,
    input  logic [NUM_REQS*2-1:0]        req_mode,
    input  logic [NUM_REQS*XLEN-1:0]     req_avl,
    input  logic [NUM_REQS*8-1:0]        req_vtype,

    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [NW_WIDTH-1:0]          rsp_wid,
    output logic [XLEN-1:0]              rsp_vl,

    VX_vpu_states_if.master              states_if,

    input  logic [NW_WIDTH-1:0]          rd_wid,
    output vpu_states_t                  rd_state,

    output logic [NUM_WARPS-1:0]         pending
`ifdef VX_VPU_STATE_PERF_EN
    ,
    output logic [31:0]                  perf_updates,
    output logic [31:0]                  perf_vill,
    output logic [31:0]                  perf_stalls
`endif
);

    localparam int RQ_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

    vpu_ctrl_state_e      state_q,   state_d;
    logic [RQ_WIDTH-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [NW_WIDTH-1:0]  wid_q,     wid_d;
    logic [1:0]           mode_q,    mode_d;
    logic [XLEN-1:0]      avl_q,     avl_d;
    vtype_t               vtype_q,   vtype_d;
    vpu_states_t          res_q,     res_d;
    vpu_states_t          table_q [NUM_WARPS];
    vpu_states_t          table_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] pending_q, pending_d;
    logic                 bcast_q,   bcast_d;

    logic                 grant_any;
    logic [RQ_WIDTH-1:0]  grant_idx;
    int unsigned          arb_idx;
    logic [NW_WIDTH-1:0]  grant_wid;

    logic [XLEN-1:0]      calc_vlmax;
    logic                 calc_vill;
    logic [XLEN-1:0]      cur_vl;
    logic [XLEN-1:0]      new_vl;
    logic                 new_vill;
    vpu_states_t          calc_state;

    vx_vpu_vlmax #(
        .VLEN (VLEN),
        .XLEN (XLEN)
    ) u_vlmax (
        .vsew  (vtype_q.vsew),
        .vlmul (vtype_q.vlmul),
        .vlmax (calc_vlmax),
        .vill  (calc_vill)
    );

    // Round-robin pick: search starts at rr_ptr_q, the requester after the last grant
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        arb_idx   = 0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            arb_idx = (32'(rr_ptr_q) + k) % NUM_REQS;
            if (!grant_any && req_valid[arb_idx]) begin
                grant_any = 1'b1;
                grant_idx = RQ_WIDTH'(arb_idx);
            end
        end
        grant_wid = req_wid[grant_idx*NW_WIDTH +: NW_WIDTH];
    end

    // New vl / vtype for the latched request; any illegal outcome collapses to vill
    always_comb begin
        cur_vl   = table_q[wid_q].vl;
        new_vl   = '0;
        new_vill = calc_vill;
        case (mode_q)
            VPU_MODE_AVL_REG: new_vl = (avl_q < calc_vlmax) ? avl_q : calc_vlmax;
            VPU_MODE_VLMAX:   new_vl = calc_vlmax;
            VPU_MODE_KEEP_VL: begin
                new_vl = cur_vl;
                if (cur_vl > calc_vlmax) begin
                    new_vill = 1'b1;
                end
            end
            default:          new_vill = 1'b1;
        endcase
        calc_state = '0;
        if (new_vill) begin
            calc_state.vill = 1'b1;
        end else begin
            calc_state.vl    = new_vl;
            calc_state.vma   = vtype_q.vma;
            calc_state.vta   = vtype_q.vta;
            calc_state.vsew  = vtype_q.vsew;
            calc_state.vlmul = vtype_q.vlmul;
        end
    end

    // Control FSM: accept in IDLE, compute in CALC, commit/broadcast entering DONE
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        wid_d     = wid_q;
        mode_d    = mode_q;
        avl_d     = avl_q;
        vtype_d   = vtype_q;
        res_d     = res_q;
        table_d   = table_q;
        pending_d = pending_q;
        bcast_d   = 1'b0;
        req_ready = '0;
        case (state_q)
            VPU_ST_IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    wid_d     = grant_wid;
                    mode_d    = req_mode[grant_idx*2 +: 2];
                    avl_d     = req_avl[grant_idx*XLEN +: XLEN];
                    vtype_d   = vtype_t'(req_vtype[grant_idx*8 +: 8]);
                    pending_d[grant_wid] = 1'b1;
                    if (32'(grant_idx) == 32'(NUM_REQS - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = grant_idx + 1'b1;
                    end
                    state_d = VPU_ST_CALC;
                end
            end
            VPU_ST_CALC: begin
                res_d          = calc_state;
                table_d[wid_q] = calc_state;
                bcast_d        = 1'b1;
                state_d        = VPU_ST_DONE;
            end
            VPU_ST_DONE: begin
                if (rsp_ready) begin
                    pending_d[wid_q] = 1'b0;
                    state_d          = VPU_ST_IDLE;
                end
            end
            default: state_d = VPU_ST_IDLE;
        endcase
    end

    // State registers; reset drops any in-flight request and reinitializes the table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= VPU_ST_IDLE;
            rr_ptr_q  <= '0;
            wid_q     <= '0;
            mode_q    <= '0;
            avl_q     <= '0;
            vtype_q   <= '0;
            res_q     <= '0;
            pending_q <= '0;
            bcast_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_WARPS; i++) begin
                table_q[i] <= VPU_STATES_RESET;
            end
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            wid_q     <= wid_d;
            mode_q    <= mode_d;
            avl_q     <= avl_d;
            vtype_q   <= vtype_d;
            res_q     <= res_d;
            pending_q <= pending_d;
            bcast_q   <= bcast_d;
            table_q   <= table_d;
        end
    end

    assign rsp_valid       = (state_q == VPU_ST_DONE);
    assign rsp_wid         = wid_q;
    assign rsp_vl          = res_q.vl;
    assign states_if.valid = bcast_q;
    assign states_if.wid   = wid_q;
    assign states_if.data  = res_q;
    assign rd_state        = table_q[rd_wid];
    assign pending         = pending_q;

`ifdef VX_VPU_STATE_PERF_EN
    logic [31:0] perf_updates_q, perf_updates_d;
    logic [31:0] perf_vill_q,    perf_vill_d;
    logic [31:0] perf_stalls_q,  perf_stalls_d;

    // Completed updates count at response handshake; stalls count unserved valids
    always_comb begin
        perf_updates_d = perf_updates_q;
        perf_vill_d    = perf_vill_q;
        perf_stalls_d  = perf_stalls_q;
        if (rsp_valid && rsp_ready) begin
            perf_updates_d = perf_updates_q + 32'd1;
            if (res_q.vill) begin
                perf_vill_d = perf_vill_q + 32'd1;
            end
        end
        if (|(req_valid & ~req_ready)) begin
            perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    // Wrapping perf counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_updates_q <= '0;
            perf_vill_q    <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_updates_q <= perf_updates_d;
            perf_vill_q    <= perf_vill_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_updates = perf_updates_q;
    assign perf_vill    = perf_vill_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule
